// File: rtl/ifetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: FSM state encodings,
// the NOP word loaded into the instruction register on reset, and the
// default first fetch address.
package ifetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,  // post-reset cycle only
      ST_FETCH = 2'd1,  // request live at pc, waiting for ack
      ST_FULL  = 2'd2,  // instruction register holds a valid word
      ST_DROP  = 2'd3   // old request still live; its response is thrown away
   } state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Force a redirect target onto a word boundary.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Single-entry instruction fetch unit.
//
// Handshakes:
//   memory side : imem_req is held high with imem_addr stable until a cycle
//                 with imem_ack=1; imem_rdata is valid in that same cycle and
//                 the request completes on that rising edge.
//   decode side : instr/instr_pc are meaningful only while instr_valid=1; the
//                 word is consumed on a rising edge where instr_valid=1 and
//                 stall=0, and held unchanged while stall=1.
//   redirect    : redirect_valid wins over ack and stall in every state and
//                 kills any word in flight or held.
//
// The FSM state is exported on dbg_state for checkers.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [6:0]  opc,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic        misalign_err,
   output logic [1:0]  dbg_state
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   // Address of the outstanding request; only differs from pc in DROP.
   logic [31:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        valid_q, valid_d;
   logic        misalign_q, misalign_d;
   logic [31:0] redirect_tgt;

   assign redirect_tgt = align_pc(redirect_pc);

   // Next-state and datapath update; every target gets a hold default first.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      misalign_d = misalign_q;
      // Track pc everywhere except DROP, so entering DROP freezes the old address.
      addr_d     = (state_q == ST_DROP) ? addr_q : pc_q;

      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         misalign_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               valid_d = 1'b0;
            end
         end

         ST_FETCH: begin
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               valid_d = 1'b0;
               // Without ack the request is still live and must be drained.
               state_d = imem_ack ? ST_FETCH : ST_DROP;
            end else if (imem_ack) begin
               instr_d    = imem_rdata;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
               pc_d       = pc_q + 32'd4;
               state_d    = ST_FULL;
            end
         end

         ST_FULL: begin
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               valid_d = 1'b0;
               state_d = ST_FETCH;
            end else if (!stall) begin
               valid_d = 1'b0;
               state_d = ST_FETCH;
            end
         end

         ST_DROP: begin
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               valid_d = 1'b0;
            end
            if (imem_ack) begin
               state_d = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         instr_q    <= NOP_INSTR;
         instr_pc_q <= 32'h0000_0000;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_req     = (state_q == ST_FETCH) || (state_q == ST_DROP);
   assign imem_addr    = (state_q == ST_DROP) ? addr_q : pc_q;
   assign instr_valid  = valid_q;
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign opc          = instr_q[6:0];
   assign funct3       = instr_q[14:12];
   assign funct7       = instr_q[31:25];
   assign misalign_err = misalign_q;
   assign dbg_state    = state_q;

endmodule
